otbn_wdr_stream_writer: RTL and testbench
=========================================

OTBN_WDR_STREAM_WRITER -- requirements
Module: otbn_wdr_stream_writer

Interface
REQ-001 SHALL have parameter BlankIdle, default 1, meaning wr_data_o is forced to zero whenever no write is presented.
REQ-002 SHALL have port clk_i  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have ports start_i  input  1, base_addr_i  input  WdrAw, num_words_i  input  WdrAw+1: transfer request, first WDR index, WDR count (0..NWdr).
REQ-005 SHALL have ports abort_i  input  1  cancel the transfer; busy_o  output  1  transfer in progress; done_o  output  1  one-cycle completion pulse.
REQ-006 SHALL have ports in_valid_i  input  1, in_ready_o  output  1, in_data_i  input  ExtWLEN/8: integrity-protected 39-bit granule stream (32 data + 7 ECC).
REQ-007 SHALL have ports wr_addr_o  output  WdrAw, wr_en_o  output  8, wr_data_o  output  ExtWLEN, wr_we_onehot_o  output  NWdr: bignum RF write port B plus its predecoded one-hot write enable.
REQ-008 SHALL have port wr_gnt_i  input  1: RF write accepted this cycle (deasserted while write port A targets the same register).

Function
REQ-009 SHALL implement states IDLE, FILL, WRITE, DONE.
REQ-010 IDLE: start_i with num_words_i>0 SHALL latch base_addr_i and num_words_i and enter FILL next cycle; num_words_i=0 SHALL enter DONE.
REQ-011 start_i outside IDLE SHALL be ignored.
REQ-012 FILL: in_ready_o=1; each beat with in_valid_i&in_ready_o SHALL store in_data_i into granule slot gran_cnt (slot k = bits [39k+:39]) and increment gran_cnt.
REQ-013 The beat filling slot 7 SHALL move to WRITE next cycle; gran_cnt SHALL wrap to 0.
REQ-014 WRITE: in_ready_o=0, wr_en_o=8'hFF, wr_addr_o=current address, wr_data_o=assembled buffer, wr_we_onehot_o=one-hot of wr_addr_o, all held stable until wr_gnt_i.
REQ-015 On wr_gnt_i in WRITE: address SHALL increment modulo NWdr (31 wraps to 0), word counter SHALL decrement; counter reaching 0 SHALL enter DONE, else FILL.
REQ-016 Outside WRITE: wr_en_o=0, wr_we_onehot_o=0, and wr_data_o=0 when BlankIdle=1.
REQ-017 wr_we_onehot_o SHALL be driven from registered state, never combinationally from in_valid_i.
REQ-018 DONE: done_o=1 for exactly one cycle, then IDLE.
REQ-019 busy_o SHALL be 1 in FILL and WRITE, 0 in IDLE and DONE.
REQ-020 abort_i in FILL or WRITE SHALL return to IDLE next cycle without write or done_o; a beat handshaking in the abort cycle SHALL be discarded; abort_i has priority over wr_gnt_i.
REQ-021 Granule data SHALL pass through unmodified; integrity is checked at RF read.
REQ-022 Minimum throughput: one WDR per 9 cycles with continuous in_valid_i and immediate wr_gnt_i.

Reset
REQ-023 Reset SHALL force IDLE, counters and address to 0, buffer to 0.
REQ-024 Reset-value outputs: busy_o=0, done_o=0, in_ready_o=0, wr_en_o=0, wr_we_onehot_o=0, wr_addr_o=0, wr_data_o=0.
REQ-025 Reset asserted mid-transfer SHALL abandon it with no write after deassertion.

Structure
REQ-026 WdrAw, NWdr, ExtWLEN, BaseIntgWidth SHALL come from otbn_pkg; state enum otbn_wdr_wr_state_e SHALL be added to otbn_pkg.
REQ-027 The granule buffer SHALL be a single sub-module otbn_wdr_granule_buf (8x39 b, slot-indexed write, parallel read).
REQ-028 State register SHALL use sparse encoding; illegal state SHALL go to IDLE.

Verification
REQ-029 start base=3 num=1, 8 beats 0x00..0x07, gnt same cycle -> one write addr 3, wr_en 8'hFF, slot k = k, onehot bit 3, done_o pulse.
REQ-030 base=30 num=3 -> writes to 30, 31, 0 in order, then one done_o.
REQ-031 gnt held low 5 cycles in WRITE -> addr/data/en stable 5 cycles, in_ready_o=0, write completes on gnt.
REQ-032 abort_i after 4 beats -> no wr_en_o, no done_o, IDLE; new start writes clean data.
REQ-033 num=0 -> done_o 2 cycles after start, no write, in_ready_o never high.
REQ-034 rst_ni low mid-FILL -> all outputs at reset values asynchronously; no write after release.

Source files
------------

// File: rtl/otbn_pkg.sv
// Shared OTBN parameters and types used by the WDR stream writer.
package otbn_pkg;

   localparam int unsigned WdrAw         = 5;
   localparam int unsigned NWdr          = 32;
   localparam int unsigned BaseIntgWidth = 39;
   localparam int unsigned ExtWLEN       = 8 * BaseIntgWidth;
   localparam int unsigned NGranules     = ExtWLEN / BaseIntgWidth;
   localparam int unsigned GranAw        = $clog2(NGranules);

   // Encodings are pairwise at least Hamming distance 3 apart.
   typedef enum logic [4:0] {
      WdrWrStIdle  = 5'b01011,
      WdrWrStFill  = 5'b10110,
      WdrWrStWrite = 5'b00101,
      WdrWrStDone  = 5'b11000
   } otbn_wdr_wr_state_e;

endpackage

// File: rtl/otbn_wdr_granule_buf.sv
// Eight-slot buffer of 39-bit integrity granules: slot-indexed write, full-width parallel read.
module otbn_wdr_granule_buf
   import otbn_pkg::*;
(
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     we_i,
   input  logic [GranAw-1:0]        slot_i,
   input  logic [BaseIntgWidth-1:0] wdata_i,
   output logic [ExtWLEN-1:0]       rdata_o
);

   logic [ExtWLEN-1:0] buf_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         buf_q <= '0;
      end else if (we_i) begin
         for (int k = 0; k < NGranules; k++) begin
            if (slot_i == GranAw'(k)) begin
               buf_q[k*BaseIntgWidth +: BaseIntgWidth] <= wdata_i;
            end
         end
      end
   end

   assign rdata_o = buf_q;

endmodule

// File: rtl/otbn_wdr_stream_writer.sv
// Collects a stream of integrity granules into full WDRs and writes them to consecutive
// bignum register file entries through write port B.
module otbn_wdr_stream_writer
   import otbn_pkg::*;
#(
   parameter bit BlankIdle = 1'b1
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     start_i,
   input  logic [WdrAw-1:0]         base_addr_i,
   input  logic [WdrAw:0]           num_words_i,
   input  logic                     abort_i,
   output logic                     busy_o,
   output logic                     done_o,
   input  logic                     in_valid_i,
   output logic                     in_ready_o,
   input  logic [BaseIntgWidth-1:0] in_data_i,
   output logic [WdrAw-1:0]         wr_addr_o,
   output logic [7:0]               wr_en_o,
   output logic [ExtWLEN-1:0]       wr_data_o,
   output logic [NWdr-1:0]          wr_we_onehot_o,
   input  logic                     wr_gnt_i
);

   localparam logic [WdrAw-1:0]  AddrOne   = WdrAw'(1);
   localparam logic [WdrAw:0]    CntOne    = (WdrAw + 1)'(1);
   localparam logic [GranAw-1:0] GranOne   = GranAw'(1);
   localparam logic [GranAw-1:0] GranLast  = GranAw'(NGranules - 1);
   localparam logic [NWdr-1:0]   OneHotLsb = NWdr'(1);

   otbn_wdr_wr_state_e state_q, state_d;
   logic [WdrAw-1:0]   addr_q, addr_d;
   logic [WdrAw:0]     cnt_q, cnt_d;
   logic [GranAw-1:0]  gran_q, gran_d;
   logic               buf_we;
   logic [ExtWLEN-1:0] buf_data;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= WdrWrStIdle;
         addr_q  <= '0;
         cnt_q   <= '0;
         gran_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         gran_q  <= gran_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      gran_d  = gran_q;
      buf_we  = 1'b0;
      case (state_q)
         WdrWrStIdle: begin
            gran_d = '0;
            if (start_i) begin
               if (num_words_i != '0) begin
                  addr_d  = base_addr_i;
                  cnt_d   = num_words_i;
                  state_d = WdrWrStFill;
               end else begin
                  state_d = WdrWrStDone;
               end
            end
         end
         WdrWrStFill: begin
            // A beat arriving together with abort is dropped.
            if (abort_i) begin
               gran_d  = '0;
               state_d = WdrWrStIdle;
            end else if (in_valid_i) begin
               buf_we = 1'b1;
               gran_d = gran_q + GranOne;
               if (gran_q == GranLast) begin
                  state_d = WdrWrStWrite;
               end
            end
         end
         WdrWrStWrite: begin
            if (abort_i) begin
               gran_d  = '0;
               state_d = WdrWrStIdle;
            end else if (wr_gnt_i) begin
               addr_d  = addr_q + AddrOne;
               cnt_d   = cnt_q - CntOne;
               state_d = (cnt_q == CntOne) ? WdrWrStDone : WdrWrStFill;
            end
         end
         WdrWrStDone: begin
            state_d = WdrWrStIdle;
         end
         default: begin
            gran_d  = '0;
            state_d = WdrWrStIdle;
         end
      endcase
   end

   otbn_wdr_granule_buf u_granule_buf (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .we_i    (buf_we),
      .slot_i  (gran_q),
      .wdata_i (in_data_i),
      .rdata_o (buf_data)
   );

   // All outputs decode from registered state only.
   always_comb begin
      busy_o         = (state_q == WdrWrStFill) || (state_q == WdrWrStWrite);
      done_o         = (state_q == WdrWrStDone);
      in_ready_o     = (state_q == WdrWrStFill);
      wr_addr_o      = addr_q;
      wr_en_o        = '0;
      wr_we_onehot_o = '0;
      wr_data_o      = BlankIdle ? '0 : buf_data;
      if (state_q == WdrWrStWrite) begin
         wr_en_o        = 8'hFF;
         wr_we_onehot_o = OneHotLsb << addr_q;
         wr_data_o      = buf_data;
      end
   end

endmodule

// File: tb/tb_otbn_wdr_stream_writer.sv
// Self-checking bench: table of transfers plus random transfers against a word-level model,
// with hand-written reset and abort sequences.
module tb_otbn_wdr_stream_writer;
   import otbn_pkg::*;

   logic                     clk = 1'b0;
   logic                     rst_n;
   logic                     start_i;
   logic [WdrAw-1:0]         base_addr_i;
   logic [WdrAw:0]           num_words_i;
   logic                     abort_i;
   logic                     busy_o;
   logic                     done_o;
   logic                     in_valid_i;
   logic                     in_ready_o;
   logic [BaseIntgWidth-1:0] in_data_i;
   logic [WdrAw-1:0]         wr_addr_o;
   logic [7:0]               wr_en_o;
   logic [ExtWLEN-1:0]       wr_data_o;
   logic [NWdr-1:0]          wr_we_onehot_o;
   logic                     wr_gnt_i;

   always #5 clk = ~clk;

   otbn_wdr_stream_writer #(.BlankIdle(1'b1)) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .start_i        (start_i),
      .base_addr_i    (base_addr_i),
      .num_words_i    (num_words_i),
      .abort_i        (abort_i),
      .busy_o         (busy_o),
      .done_o         (done_o),
      .in_valid_i     (in_valid_i),
      .in_ready_o     (in_ready_o),
      .in_data_i      (in_data_i),
      .wr_addr_o      (wr_addr_o),
      .wr_en_o        (wr_en_o),
      .wr_data_o      (wr_data_o),
      .wr_we_onehot_o (wr_we_onehot_o),
      .wr_gnt_i       (wr_gnt_i)
   );

   int total = 0;
   int bad   = 0;

   // abort_at: -1 none, 0..7 abort in FILL at that beat, 99 abort with gnt in first WRITE
   typedef struct {
      int base;
      int num;
      int gdly;
      int abort_at;
      bit fixed;
      int n_wr;
      int n_done;
   } vec_t;

   vec_t tbl[8];

   task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      start_i    = 1'b0;
      abort_i    = 1'b0;
      in_valid_i = 1'b0;
      wr_gnt_i   = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_busy"}, busy_o, 0);
      chk({tag, "_done"}, done_o, 0);
      chk({tag, "_ready"}, in_ready_o, 0);
      chk({tag, "_wr_en"}, wr_en_o, 0);
      chk({tag, "_onehot"}, wr_we_onehot_o, 0);
      chk({tag, "_addr"}, wr_addr_o, 0);
      chk({tag, "_data"}, wr_data_o, 0);
   endtask

   task automatic run_xfer(input vec_t v);
      logic [ExtWLEN-1:0] words[$];
      logic [ExtWLEN-1:0] w;
      logic [NWdr-1:0]    oh;
      int beats = 0, writes = 0, dones = 0, wait_cnt = 0, dly = 0, cyc = 0;
      int abort_cyc = -1, done_cyc = -1;
      bit finished = 1'b0;
      for (int i = 0; i < v.num; i++) begin
         w = '0;
         for (int k = 0; k < NGranules; k++) begin
            w[k*BaseIntgWidth +: BaseIntgWidth] =
               v.fixed ? BaseIntgWidth'(k) : BaseIntgWidth'({$urandom, $urandom});
         end
         words.push_back(w);
      end
      dly = (v.gdly < 0) ? $urandom_range(0, 3) : v.gdly;
      @(negedge clk);
      start_i     = 1'b1;
      base_addr_i = WdrAw'(v.base);
      num_words_i = (WdrAw + 1)'(v.num);
      while (!finished && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         idle_inputs();
         in_data_i = BaseIntgWidth'({$urandom, $urandom});
         if (done_o) begin
            dones++;
            done_cyc = cyc;
            chk("writes_before_done", writes, v.n_wr);
            chk("busy_in_done", busy_o, 0);
            if (v.num == 0) chk("num0_done_within_2", cyc <= 2, 1);
         end else if (done_cyc >= 0) begin
            chk("busy_after_done", busy_o, 0);
            finished = 1'b1;
         end
         if (wr_en_o != '0) begin
            chk("no_write_after_abort", abort_cyc < 0, 1);
            chk("write_within_count", writes < v.num, 1);
            chk("wr_en_all", wr_en_o, 8'hFF);
            chk("ready_low_in_write", in_ready_o, 0);
            if (writes < v.num) begin
               oh = '0;
               oh[(v.base + writes) % NWdr] = 1'b1;
               chk("wr_addr", wr_addr_o, (v.base + writes) % NWdr);
               chk("wr_data", wr_data_o, words[writes]);
               chk("wr_onehot", wr_we_onehot_o, oh);
            end
            if (v.abort_at == 99 && abort_cyc < 0) begin
               abort_i   = 1'b1;
               wr_gnt_i  = 1'b1;
               abort_cyc = cyc;
            end else if (abort_cyc < 0) begin
               if (wait_cnt >= dly) begin
                  wr_gnt_i = 1'b1;
                  writes++;
                  wait_cnt = 0;
                  dly = (v.gdly < 0) ? $urandom_range(0, 3) : v.gdly;
               end else begin
                  wait_cnt++;
               end
            end
         end else begin
            chk("data_blank_idle", wr_data_o, 0);
            chk("onehot_idle", wr_we_onehot_o, 0);
         end
         if (in_ready_o) begin
            chk("ready_within_beats", beats < v.num * NGranules, 1);
            chk("ready_after_abort", abort_cyc < 0, 1);
            if (v.abort_at >= 0 && v.abort_at < 8 && abort_cyc < 0 && beats == v.abort_at) begin
               abort_i    = 1'b1;
               in_valid_i = 1'b1;
               abort_cyc  = cyc;
            end else if ($urandom_range(0, 3) != 0 && beats < v.num * NGranules) begin
               in_valid_i = 1'b1;
               w = words[beats / NGranules];
               in_data_i = w[(beats % NGranules)*BaseIntgWidth +: BaseIntgWidth];
               beats++;
            end
         end
         // Starts during a transfer must be ignored.
         if (busy_o && abort_cyc < 0 && $urandom_range(0, 7) == 0) begin
            start_i     = 1'b1;
            base_addr_i = WdrAw'($urandom);
            num_words_i = (WdrAw + 1)'($urandom_range(0, 32));
         end
         if (abort_cyc >= 0 && cyc == abort_cyc + 1) chk("busy_after_abort", busy_o, 0);
         if (abort_cyc >= 0 && cyc >= abort_cyc + 6) finished = 1'b1;
      end
      idle_inputs();
      chk("xfer_finished", finished, 1);
      chk("write_count", writes, v.n_wr);
      chk("done_count", dones, v.n_done);
   endtask

   initial begin
      int nwr, nbusy, ndone;
      vec_t v;
      tbl[0] = '{3, 1, 0, -1, 1'b1, 1, 1};
      tbl[1] = '{30, 3, 0, -1, 1'b0, 3, 1};
      tbl[2] = '{5, 1, 5, -1, 1'b0, 1, 1};
      tbl[3] = '{7, 2, 0, 4, 1'b0, 0, 0};
      tbl[4] = '{9, 1, 0, -1, 1'b1, 1, 1};
      tbl[5] = '{0, 0, 0, -1, 1'b0, 0, 1};
      tbl[6] = '{20, 2, 1, 99, 1'b0, 0, 0};
      tbl[7] = '{12, 32, -1, -1, 1'b0, 32, 1};

      rst_n       = 1'b0;
      idle_inputs();
      base_addr_i = '0;
      num_words_i = '0;
      in_data_i   = '0;
      #12;
      chk_reset_outputs("por");
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) run_xfer(tbl[i]);

      for (int i = 0; i < 10; i++) begin
         v.base     = $urandom_range(0, NWdr - 1);
         v.num      = $urandom_range(1, 4);
         v.gdly     = -1;
         v.fixed    = 1'b0;
         v.abort_at = (i % 4 == 3) ? $urandom_range(0, 7) : -1;
         v.n_wr     = (v.abort_at < 0) ? v.num : 0;
         v.n_done   = (v.abort_at < 0) ? 1 : 0;
         run_xfer(v);
      end

      // Reset in the middle of FILL must clear outputs without waiting for a clock edge.
      @(negedge clk);
      start_i     = 1'b1;
      base_addr_i = WdrAw'(4);
      num_words_i = (WdrAw + 1)'(2);
      @(negedge clk);
      start_i = 1'b0;
      chk("fill_ready_before_rst", in_ready_o, 1);
      for (int b = 0; b < 3; b++) begin
         in_valid_i = 1'b1;
         in_data_i  = BaseIntgWidth'({$urandom, $urandom});
         @(negedge clk);
      end
      in_valid_i = 1'b0;
      chk("addr_before_rst", wr_addr_o, 4);
      #2 rst_n = 1'b0;
      #1 chk_reset_outputs("async_rst");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      nwr = 0; nbusy = 0; ndone = 0;
      for (int c = 0; c < 20; c++) begin
         in_valid_i = ($urandom_range(0, 1) == 1);
         in_data_i  = BaseIntgWidth'({$urandom, $urandom});
         @(negedge clk);
         if (wr_en_o != '0) nwr++;
         if (busy_o) nbusy++;
         if (done_o) ndone++;
      end
      in_valid_i = 1'b0;
      chk("no_write_after_rst", nwr, 0);
      chk("no_busy_after_rst", nbusy, 0);
      chk("no_done_after_rst", ndone, 0);

      run_xfer(tbl[4]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
